// File: rtl/spike_aer_dispatcher.sv
// Drains the spike-address FIFO into the tinyODIN AER input port with a 4-phase REQ/ACK handshake.
// After each filter tick it issues one time-reference event. Optional ACK timeout: define SPIKE_AER_TIMEOUT_EN.
module spike_aer_dispatcher #(
    parameter int N       = 256,
    parameter int M       = $clog2(N),
    parameter int TIMEOUT = 1023
) (
    input  logic         CLK,
    input  logic         RST,
    output logic         FIFO_r_en_o,
    input  logic [M-1:0] FIFO_r_data_i,
    input  logic         FIFO_empty_i,
    input  logic         tick_done_i,
    output logic [M+1:0] AERIN_ADDR_o,
    output logic         AERIN_REQ_o,
    input  logic         AERIN_ACK_i,
    output logic         busy_o,
    output logic [15:0]  event_count_o,
    output logic         tick_overrun_o,
    output logic         timeout_err_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        LOAD      = 3'd2,
        LOAD_TREF = 3'd3,
        REQ       = 3'd4,
        RELEASE   = 3'd5
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic           ack_meta_r;
    logic           ack_sync_r;
    logic           ack_s;
    logic           tref_pending_r;
    logic           overrun_r;
    logic [M+1:0]   addr_r;
    logic [15:0]    event_count_r;
    logic           evt_done_s;
    logic           to_hit_s;

    assign ack_s = ack_sync_r;

`ifdef SPIKE_AER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT + 1) < 10) ? 10 : $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt_r;
    logic          timeout_err_r;

    assign to_hit_s = ((state_r == REQ) || (state_r == RELEASE)) &&
                      (to_cnt_r == TW'(TIMEOUT - 1));

    // Handshake watchdog: counts cycles spent in one handshake state
    always_ff @(posedge CLK) begin
        if (RST) begin
            to_cnt_r      <= '0;
            timeout_err_r <= 1'b0;
        end else begin
            if ((state_s != state_r) || !((state_r == REQ) || (state_r == RELEASE))) begin
                to_cnt_r <= '0;
            end else begin
                to_cnt_r <= to_cnt_r + TW'(1);
            end
            if (to_hit_s) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign timeout_err_o = timeout_err_r;
`else
    logic unused_timeout_s;

    assign unused_timeout_s = (TIMEOUT == 0);
    assign to_hit_s         = 1'b0;
    assign timeout_err_o    = 1'b0;
`endif

    // Next-state decode; spikes always win over a pending time reference
    always_comb begin
        state_s    = state_r;
        evt_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (!FIFO_empty_i) begin
                    state_s = POP;
                end else if (tref_pending_r) begin
                    state_s = LOAD_TREF;
                end else begin
                    state_s = IDLE;
                end
            end
            POP:       state_s = LOAD;
            LOAD:      state_s = REQ;
            LOAD_TREF: state_s = REQ;
            REQ: begin
                if (to_hit_s) begin
                    state_s = IDLE;
                end else if (ack_s) begin
                    state_s = RELEASE;
                end else begin
                    state_s = REQ;
                end
            end
            RELEASE: begin
                if (to_hit_s) begin
                    state_s = IDLE;
                end else if (!ack_s) begin
                    state_s    = IDLE;
                    evt_done_s = 1'b1;
                end else begin
                    state_s = RELEASE;
                end
            end
            default:   state_s = IDLE;
        endcase
    end

    // State, ACK synchronizer, event word and status registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r        <= IDLE;
            ack_meta_r     <= 1'b0;
            ack_sync_r     <= 1'b0;
            tref_pending_r <= 1'b0;
            overrun_r      <= 1'b0;
            addr_r         <= '0;
            event_count_r  <= 16'd0;
        end else begin
            state_r    <= state_s;
            ack_meta_r <= AERIN_ACK_i;
            ack_sync_r <= ack_meta_r;
            // a new tick re-arms the reference even while it is being loaded
            tref_pending_r <= tick_done_i | (tref_pending_r & (state_r != LOAD_TREF));
            if (tick_done_i && tref_pending_r) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
            if (state_r == LOAD) begin
                addr_r <= {2'b00, FIFO_r_data_i};
            end else if (state_r == LOAD_TREF) begin
                addr_r <= {2'b01, {M{1'b0}}};
            end else begin
                addr_r <= addr_r;
            end
            if (evt_done_s) begin
                event_count_r <= event_count_r + 16'd1;
            end else begin
                event_count_r <= event_count_r;
            end
        end
    end

    assign FIFO_r_en_o    = (state_r == POP);
    assign AERIN_REQ_o    = (state_r == REQ);
    assign AERIN_ADDR_o   = addr_r;
    assign event_count_o  = event_count_r;
    assign tick_overrun_o = overrun_r;
    assign busy_o         = (state_r != IDLE) | tref_pending_r | ~FIFO_empty_i;

endmodule

// File: tb/tb_spike_aer_dispatcher.sv
// Randomised bench for spike_aer_dispatcher: FIFO model, AER core responder and an
// expected-event scoreboard derived from the dispatch rules (spikes in order, then one tick reference).
module tb_spike_aer_dispatcher;

    localparam int M = 8;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         FIFO_r_en_o;
    logic [M-1:0] FIFO_r_data_i = '0;
    logic         FIFO_empty_i = 1'b1;
    logic         tick_done_i = 1'b0;
    logic [M+1:0] AERIN_ADDR_o;
    logic         AERIN_REQ_o;
    logic         AERIN_ACK_i = 1'b0;
    logic         busy_o;
    logic [15:0]  event_count_o;
    logic         tick_overrun_o;
    logic         timeout_err_o;

    spike_aer_dispatcher dut (
        .CLK            (CLK),
        .RST            (RST),
        .FIFO_r_en_o    (FIFO_r_en_o),
        .FIFO_r_data_i  (FIFO_r_data_i),
        .FIFO_empty_i   (FIFO_empty_i),
        .tick_done_i    (tick_done_i),
        .AERIN_ADDR_o   (AERIN_ADDR_o),
        .AERIN_REQ_o    (AERIN_REQ_o),
        .AERIN_ACK_i    (AERIN_ACK_i),
        .busy_o         (busy_o),
        .event_count_o  (event_count_o),
        .tick_overrun_o (tick_overrun_o),
        .timeout_err_o  (timeout_err_o)
    );

    always #5 CLK = ~CLK;

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [7:0]  fifo_q[$];
    logic [31:0] exp_q[$];
    int          pushes = 0;
    int          pops = 0;
    int          bad_pops = 0;
    int          count_exp = 0;
    logic        ovr_exp = 1'b0;
    int          ack_delay = 2;
    int          rel_delay = 0;
    logic        hs_active = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // FIFO model: pop mid-cycle on the strobe, data valid for the following cycle
    always begin
        @(negedge CLK);
        #2;
        if (FIFO_r_en_o) begin
            pops++;
            if (fifo_q.size() == 0) begin
                bad_pops++;
            end else begin
                FIFO_r_data_i = fifo_q.pop_front();
            end
        end
        FIFO_empty_i = (fifo_q.size() == 0);
    end

    // Core responder: scoreboards each request word and completes the 4-phase handshake
    initial begin
        forever begin
            @(negedge CLK);
            if (AERIN_REQ_o) begin
                hs_active = 1'b1;
                if (exp_q.size() == 0) begin
                    check_value("aer_extra", 32'(AERIN_ADDR_o), 32'hFFFF_FFFF);
                end else begin
                    check_value("aer_word", 32'(AERIN_ADDR_o), exp_q.pop_front());
                end
                repeat (ack_delay) @(negedge CLK);
                AERIN_ACK_i = 1'b1;
                for (int i = 0; i < 400; i++) begin
                    if (!AERIN_REQ_o) break;
                    @(negedge CLK);
                end
                repeat (rel_delay) @(negedge CLK);
                AERIN_ACK_i = 1'b0;
                hs_active   = 1'b0;
            end
        end
    end

    task automatic push_spike(input logic [7:0] a);
        fifo_q.push_back(a);
        exp_q.push_back({22'd0, 2'b00, a});
        pushes++;
    endtask

    task automatic wait_idle();
        repeat (2) @(negedge CLK);
        for (int i = 0; i < 3000; i++) begin
            if (!busy_o && !hs_active) break;
            @(negedge CLK);
        end
        check_value("idle_reached", {31'd0, busy_o | hs_active}, 32'd0);
    endtask

    task automatic check_status();
        check_value("event_count", 32'(event_count_o), 32'(count_exp[15:0]));
        check_value("tick_overrun", 32'(tick_overrun_o), 32'(ovr_exp));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int p;
        repeat (3) @(negedge CLK);
        check_value("rst_ren", 32'(FIFO_r_en_o), 32'd0);
        check_value("rst_req", 32'(AERIN_REQ_o), 32'd0);
        check_value("rst_addr", 32'(AERIN_ADDR_o), 32'd0);
        check_value("rst_busy", 32'(busy_o), 32'd0);
        check_status();
        RST = 1'b0;
        repeat (2) @(negedge CLK);

        // three spikes, ACK two cycles after REQ, with pop/REQ latency checks
        ack_delay = 2;
        rel_delay = 0;
        push_spike(8'd3);
        push_spike(8'd17);
        push_spike(8'd255);
        @(negedge CLK);
        check_value("lat_pop", 32'(FIFO_r_en_o), 32'd1);
        @(negedge CLK);
        check_value("lat_pop_once", 32'(FIFO_r_en_o), 32'd0);
        @(negedge CLK);
        check_value("lat_req", 32'(AERIN_REQ_o), 32'd1);
        check_value("lat_addr", 32'(AERIN_ADDR_o), 32'h003);
        count_exp += 3;
        wait_idle();
        check_status();
        check_value("pops_tp1", 32'(pops), 32'd3);

        // tick pulse during the first pop: spike goes first, then the reference
        push_spike(8'd5);
        exp_q.push_back(32'h100);
        @(negedge CLK);
        tick_done_i = 1'b1;
        @(negedge CLK);
        tick_done_i = 1'b0;
        count_exp += 2;
        wait_idle();
        check_status();

        // second tick while the reference is still pending behind spikes
        ack_delay = 5;
        push_spike(8'h21);
        push_spike(8'h22);
        exp_q.push_back(32'h100);
        tick_done_i = 1'b1;
        @(negedge CLK);
        tick_done_i = 1'b0;
        repeat (2) @(negedge CLK);
        tick_done_i = 1'b1;
        @(negedge CLK);
        tick_done_i = 1'b0;
        count_exp += 3;
        ovr_exp = 1'b1;
        wait_idle();
        check_status();

        // randomised batches: K spikes, P tick pulses while the batch is in flight
        for (int b = 0; b < 24; b++) begin
            ack_delay = $urandom_range(3, 0);
            rel_delay = $urandom_range(3, 0);
            k = $urandom_range(6, 1);
            p = $urandom_range(2, 0);
            for (int j = 0; j < k; j++) push_spike(8'($urandom_range(255, 0)));
            if (p >= 1) exp_q.push_back(32'h100);
            count_exp += k + ((p >= 1) ? 1 : 0);
            if (p >= 2) ovr_exp = 1'b1;
            tick_done_i = (p >= 1);
            @(negedge CLK);
            tick_done_i = 1'b0;
            if (p >= 2) begin
                repeat (2) @(negedge CLK);
                tick_done_i = 1'b1;
                @(negedge CLK);
                tick_done_i = 1'b0;
            end
            wait_idle();
            check_status();
        end

        // reset mid-handshake: request drops, event lost and uncounted
        ack_delay = 20;
        rel_delay = 0;
        push_spike(8'h42);
        for (int i = 0; i < 50; i++) begin
            if (AERIN_REQ_o) break;
            @(negedge CLK);
        end
        check_value("mid_req_seen", 32'(AERIN_REQ_o), 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        check_value("mid_req_drop", 32'(AERIN_REQ_o), 32'd0);
        check_value("mid_busy", 32'(busy_o), 32'(!FIFO_empty_i));
        count_exp = 0;
        ovr_exp   = 1'b0;
        check_status();
        RST = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!hs_active) break;
            @(negedge CLK);
        end

        // recovery after reset
        ack_delay = 1;
        push_spike(8'h80);
        push_spike(8'h00);
        count_exp += 2;
        wait_idle();
        check_status();

        check_value("pop_count", 32'(pops), 32'(pushes));
        check_value("pop_while_empty", 32'(bad_pops), 32'd0);
        check_value("sb_leftover", 32'(exp_q.size()), 32'd0);
        check_value("timeout_err", 32'(timeout_err_o), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
